ws2812_frame_source: RTL

- Upstream feeder for the WS2812 serializer: holds a per-LED colour frame buffer written by the host, applies a global brightness scale, and streams bytes in GRB order over the serializer's trigger / data_request / data_valid handshake.
- Enforces an inter-frame gap so a new frame is never triggered while the serializer is still transmitting or in its reset tail.

---
 rtl/ws2812_frame_source_pkg.sv | 38 +++
 rtl/ws2812_frame_ram.sv | 26 ++
 rtl/ws2812_frame_source.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ws2812_frame_source_pkg.sv
// Shared definitions for the WS2812 frame source: byte order, FSM states,
// inter-frame gap derivation and the brightness scaling helper.
package ws2812_frame_source_pkg;

    // Position of a byte within one LED's GRB triplet.
    localparam logic [1:0] SUB_G = 2'd0;
    localparam logic [1:0] SUB_R = 2'd1;
    localparam logic [1:0] SUB_B = 2'd2;

    // Inter-frame gap in microseconds: 8 bit times (10 us at 1.25 us/bit),
    // the serializer's 60 us reset tail, and margin.
    localparam int unsigned GAP_US = 80;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SCALE,
        ST_PRIME,
        ST_READY,
        ST_GAP
    } fs_state_t;

    // floor(GAP_US * 1e-6 * clk_hz) in integer arithmetic, so the result is
    // exact rather than subject to real rounding; never less than one cycle.
    function automatic int unsigned gap_cycles(input int unsigned clk_hz);
        logic [63:0] n;
        n = 64'(clk_hz) * 64'(GAP_US) / 64'd1_000_000;
        return (n == 64'd0) ? 32'd1 : 32'(n);
    endfunction

    // (c * (b + 1)) >> 8 with a 16-bit product: b=255 is identity, b=0 is black.
    function automatic logic [7:0] scale_byte(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'(c) * (16'(b) + 16'd1);
        return prod[15:8];
    endfunction

endpackage

// File: rtl/ws2812_frame_ram.sv
// Synchronous single-port-write / single-port-read RAM, read-first on a
// same-address collision, one cycle of read latency.
module ws2812_frame_ram #(
    parameter  int unsigned DEPTH = 8,
    parameter  int unsigned WIDTH = 24,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write and registered read on the same edge; the read sees the old word.
    always_ff @(posedge clk) begin
        if (we && (32'(waddr) < DEPTH)) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/ws2812_frame_source.sv
// Frame source for the WS2812 serializer: streams the frame buffer as scaled
// GRB bytes over the trigger / data_request / data_valid handshake and holds
// off the next frame until the serializer's reset tail has elapsed.
module ws2812_frame_source
    import ws2812_frame_source_pkg::*;
#(
    parameter  int unsigned INPUT_CLOCK = 12_000_000,
    parameter  int unsigned NUM_LEDS    = 8,
    localparam int unsigned AW          = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    brightness,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [23:0]   wr_rgb,
    output logic          trigger,
    output logic [7:0]    data_out,
    output logic          data_valid,
    input  logic          data_request,
    output logic          busy,
    output logic          frame_done
);

    localparam int unsigned GAP_CYCLES = gap_cycles(INPUT_CLOCK);
    localparam int unsigned GW         = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    fs_state_t       state, state_nx;
    logic [AW-1:0]   led_idx;
    logic [1:0]      sub_idx;
    logic [7:0]      bright_q;
    logic [GW-1:0]   gap_cnt;
    logic [23:0]     rd_rgb;
    logic [7:0]      sel_byte;
    logic            consume;
    logic            last_byte;
    logic            first_byte;

    ws2812_frame_ram #(
        .DEPTH (NUM_LEDS),
        .WIDTH (24)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_rgb),
        .raddr (led_idx),
        .rdata (rd_rgb)
    );

    assign consume    = data_request && data_valid;
    assign last_byte  = (led_idx == AW'(NUM_LEDS - 1)) && (sub_idx == SUB_B);
    assign first_byte = (led_idx == '0) && (sub_idx == SUB_G);

    // Pick the colour channel for the current byte position (GRB order).
    always_comb begin
        sel_byte = rd_rgb[7:0];
        case (sub_idx)
            SUB_G:   sel_byte = rd_rgb[15:8];
            SUB_R:   sel_byte = rd_rgb[23:16];
            default: sel_byte = rd_rgb[7:0];
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_FETCH;
            ST_FETCH: state_nx = ST_SCALE;
            ST_SCALE: state_nx = first_byte ? ST_PRIME : ST_READY;
            ST_PRIME: state_nx = ST_READY;
            ST_READY: if (consume) state_nx = last_byte ? ST_GAP : ST_FETCH;
            ST_GAP:   if (gap_cnt == '0) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the state.
    always_comb begin
        trigger    = (state == ST_PRIME);
        data_valid = (state == ST_PRIME) || (state == ST_READY);
        busy       = (state != ST_IDLE);
        frame_done = (state == ST_GAP) && (gap_cnt == '0);
    end

    // Datapath: brightness latch, byte position, scaled byte and gap counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_idx  <= '0;
            sub_idx  <= SUB_G;
            bright_q <= '0;
            data_out <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bright_q <= brightness;
                        led_idx  <= '0;
                        sub_idx  <= SUB_G;
                    end
                end
                ST_SCALE: data_out <= scale_byte(sel_byte, bright_q);
                ST_READY: begin
                    if (consume) begin
                        if (last_byte) begin
                            gap_cnt <= GW'(GAP_CYCLES - 1);
                        end else if (sub_idx == SUB_B) begin
                            sub_idx <= SUB_G;
                            led_idx <= led_idx + AW'(1);
                        end else begin
                            sub_idx <= sub_idx + 2'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
                end
                default: ;
            endcase
        end
    end

    // The serializer cannot have seen trigger yet, so it must not request in PRIME.
    a_no_consume_in_prime: assert property (
        @(posedge clk) disable iff (rst) !((state == ST_PRIME) && data_request)
    );

endmodule
